// File: rtl/mem_stage_pkg.sv
// Shared widths and the bubble encoding for the EXE/MEM control bundle.
package mem_stage_pkg;
    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic [RW-1:0] rdrt;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: combinational read, synchronous write,
// optional clear while reset is asserted (INIT_ZERO).
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int INIT_ZERO = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    generate
        if (INIT_ZERO != 0) begin : g_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (we) begin
                    mem[addr] <= wdata;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (we) mem[addr] <= wdata;
            end
        end
    endgenerate
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE/MEM register plus data memory access.
// Define MEM_ALIGN_CHECK_EN to block misaligned accesses and raise sticky misalign.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int INIT_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          wreg,
    input  logic          m2reg,
    input  logic          wmem,
    input  logic [RW-1:0] rdrt,
    input  logic [DW-1:0] aluout,
    input  logic [DW-1:0] qb,
    output logic          mwreg,
    output logic          mm2reg,
    output logic          mwmem,
    output logic [RW-1:0] mrdrt,
    output logic [DW-1:0] malu,
    output logic [DW-1:0] mdo,
    output logic          mvalid,
    output logic          misalign
);
    localparam int AW = $clog2(DEPTH);

    ctrl_t         ctrl;
    logic [DW-1:0] mqb;
    logic          bad;
    logic          we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= CTRL_BUBBLE;
            malu   <= '0;
            mqb    <= '0;
            mvalid <= 1'b0;
        end else if (flush) begin
            ctrl   <= CTRL_BUBBLE;
            mvalid <= 1'b0;
        end else if (!stall) begin
            ctrl   <= '{wreg, m2reg, wmem, rdrt};
            malu   <= aluout;
            mqb    <= qb;
            mvalid <= 1'b1;
        end
    end

    assign mwreg  = ctrl.wreg;
    assign mm2reg = ctrl.m2reg;
    assign mwmem  = ctrl.wmem;
    assign mrdrt  = ctrl.rdrt;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad = mvalid & (ctrl.wmem | ctrl.m2reg) & (malu[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   misalign <= 1'b0;
        else if (bad) misalign <= 1'b1;
    end
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif

    // Write only in the cycle the register advances, so a stalled store commits once.
    assign we = mvalid & ctrl.wmem & ~stall & ~bad;

    data_mem #(
        .DEPTH     (DEPTH),
        .INIT_ZERO (INIT_ZERO)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (malu[AW+1:2]),
        .wdata (mqb),
        .rdata (mdo)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a word-array reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic wreg = 1'b0, m2reg = 1'b0, wmem = 1'b0;
    logic [4:0] rdrt = '0;
    logic [31:0] aluout = '0, qb = '0;
    logic mwreg, mm2reg, mwmem, mvalid, misalign;
    logic [4:0] mrdrt;
    logic [31:0] malu, mdo;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .rdrt(rdrt),
        .aluout(aluout), .qb(qb),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrdrt(mrdrt),
        .malu(malu), .mdo(mdo), .mvalid(mvalid), .misalign(misalign)
    );

    int n_cmp = 0, n_err = 0;

    // Reference model: the instruction currently in MEM and the memory words.
    logic m_wreg, m_m2reg, m_wmem, m_valid, m_mis;
    logic [4:0] m_rd;
    logic [31:0] m_alu, m_qb;
    logic [31:0] mem_m [DEPTH];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        {m_wreg, m_m2reg, m_wmem, m_valid, m_mis} = '0;
        m_rd = '0; m_alu = '0; m_qb = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic model_edge();
        bit unaligned;
        unaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        unaligned = m_valid && (m_wmem || m_m2reg) && (m_alu % 4 != 0);
        if (unaligned) m_mis = 1'b1;
`endif
        if (m_valid && m_wmem && !stall && !unaligned) mem_m[widx(m_alu)] = m_qb;
        if (flush) begin
            {m_wreg, m_m2reg, m_wmem, m_valid} = '0;
            m_rd = '0;
        end else if (!stall) begin
            m_wreg = wreg; m_m2reg = m2reg; m_wmem = wmem; m_rd = rdrt;
            m_alu = aluout; m_qb = qb; m_valid = 1'b1;
        end
    endtask

    task automatic cyc(input logic st, input logic fl, input logic wr, input logic m2,
                       input logic wm, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d);
        stall = st; flush = fl; wreg = wr; m2reg = m2; wmem = wm;
        rdrt = rd; aluout = a; qb = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, mrdrt, malu, mvalid, misalign} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {mwreg, mm2reg, mwmem, mrdrt, malu, mvalid, misalign});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 1, 0, 5'd1, i * 4, 32'h0);
            n_cmp++;
            if (mdo !== 32'h0 || mvalid !== 1'b1) begin
                n_err++;
                $display("FAIL reset_clear word %0d: got mdo=%h mvalid=%b want 0/1", i, mdo, mvalid);
            end
        end
    endtask

    task automatic test_store_load();
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h10, 32'hDEADBEEF);
        n_cmp++;
        if ({mvalid, mwmem, mm2reg, malu} !== {1'b1, 1'b1, 1'b0, 32'h10}) begin
            n_err++;
            $display("FAIL store_stage: got v=%b wm=%b m2=%b alu=%h want 1/1/0/10",
                     mvalid, mwmem, mm2reg, malu);
        end
        cyc(0, 0, 1, 1, 0, 5'd7, 32'h10, 32'h0);
        n_cmp++;
        if ({mdo, mm2reg, mwreg, mrdrt} !== {32'hDEADBEEF, 1'b1, 1'b1, 5'd7}) begin
            n_err++;
            $display("FAIL store_load: got mdo=%h m2=%b wr=%b rd=%0d want deadbeef/1/1/7",
                     mdo, mm2reg, mwreg, mrdrt);
        end
    endtask

    task automatic test_stall();
        cyc(0, 0, 0, 0, 1, 5'd3, 32'h8, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 1, 5'd9, 32'h8, 32'h00000BAD);
            n_cmp++;
            if ({malu, mwmem, mvalid, mrdrt, mdo} !== {32'h8, 1'b1, 1'b1, 5'd3, 32'h0}) begin
                n_err++;
                $display("FAIL stall_hold %0d: got alu=%h wm=%b v=%b rd=%0d mdo=%h want 8/1/1/3/0",
                         i, malu, mwmem, mvalid, mrdrt, mdo);
            end
        end
        cyc(0, 0, 1, 1, 0, 5'd4, 32'h8, 32'h0);
        n_cmp++;
        if ({mdo, mm2reg, mwmem, mrdrt} !== {32'h12345678, 1'b1, 1'b0, 5'd4}) begin
            n_err++;
            $display("FAIL stall_resume: got mdo=%h m2=%b wm=%b rd=%0d want 12345678/1/0/4",
                     mdo, mm2reg, mwmem, mrdrt);
        end
    endtask

    task automatic test_flush_stall();
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h4, 32'hA5A5A5A5);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        cyc(1, 1, 1, 0, 1, 5'd6, 32'h4, 32'h5A5A5A5A);
        n_cmp++;
        if ({mvalid, mwmem, mwreg, mm2reg, mrdrt} !== '0) begin
            n_err++;
            $display("FAIL flush_bubble: got v=%b wm=%b wr=%b m2=%b rd=%0d want all 0",
                     mvalid, mwmem, mwreg, mm2reg, mrdrt);
        end
        cyc(0, 0, 1, 1, 0, 5'd2, 32'h4, 32'h0);
        n_cmp++;
        if (mdo !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL flush_word1: got %h want a5a5a5a5", mdo);
        end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h100, 32'h0BADF00D);
        cyc(0, 0, 1, 1, 0, 5'd1, 32'h0, 32'h0);
        n_cmp++;
        if (mdo !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL wrap_0x100: got %h want 0badf00d", mdo);
        end
        cyc(0, 0, 1, 1, 0, 5'd1, 32'h8000_0000, 32'h0);
        n_cmp++;
        if (mdo !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL wrap_high: got %h want 0badf00d", mdo);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(0, 255) * 4;
            if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) a = a | ($urandom << 10);
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 31)), a, $urandom);
            n_cmp++;
            if ({mwreg, mm2reg, mwmem, mrdrt, mvalid, misalign} !==
                {m_wreg, m_m2reg, m_wmem, m_rd, m_valid, m_mis}) begin
                n_err++;
                $display("FAIL rand_ctrl %0d: got %h want %h", n,
                         {mwreg, mm2reg, mwmem, mrdrt, mvalid, misalign},
                         {m_wreg, m_m2reg, m_wmem, m_rd, m_valid, m_mis});
            end
            if (m_valid) begin
                n_cmp++;
                if (malu !== m_alu || mdo !== mem_m[widx(m_alu)]) begin
                    n_err++;
                    $display("FAIL rand_data %0d: got alu=%h mdo=%h want %h/%h", n,
                             malu, mdo, m_alu, mem_m[widx(m_alu)]);
                end
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_word;
        logic exp_mis;
`ifdef MEM_ALIGN_CHECK_EN
        exp_word = 32'h11111111; exp_mis = 1'b1;
`else
        exp_word = 32'h22222222; exp_mis = 1'b0;
`endif
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h4, 32'h11111111);
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h6, 32'h22222222);
        cyc(0, 0, 1, 1, 0, 5'd5, 32'h4, 32'h0);
        n_cmp++;
        if (mdo !== exp_word || misalign !== exp_mis) begin
            n_err++;
            $display("FAIL misalign_store: got mdo=%h mis=%b want %h/%b", mdo, misalign, exp_word, exp_mis);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
            n_cmp++;
            if (misalign !== exp_mis) begin
                n_err++;
                $display("FAIL misalign_sticky %0d: got %b want %b", i, misalign, exp_mis);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 0, 0, 1, 5'd3, 32'h20, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, mrdrt, malu, mvalid, misalign} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h want 0",
                     {mwreg, mm2reg, mwmem, mrdrt, malu, mvalid, misalign});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 1, 1, 0, 5'd1, 32'h20, 32'h0);
        n_cmp++;
        if (mdo !== 32'h0 || mdo !== mem_m[widx(32'h20)]) begin
            n_err++;
            $display("FAIL async_no_commit: got %h want 0", mdo);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store_load();
        test_stall();
        test_flush_stall();
        test_wrap();
        test_random();
        test_misalign();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
